// File: rtl/cnt_sched_pkg.sv
// Shared definitions for the counter scheduler: FSM state encoding and default sizing.
package cnt_sched_pkg;

    localparam int unsigned DEF_N_REQ = 4;
    localparam int unsigned DEF_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/cnt_sched_ctr.sv
// Shared interval up-counter: async clear, synchronous clear, clock enable.
module cnt_sched_ctr
    import cnt_sched_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             C,
    input  logic             CLR,
    input  logic             SCLR,
    input  logic             CE,
    output logic [CNT_W-1:0] Q
);

    logic [CNT_W-1:0] r_q;

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            r_q <= '0;
        end else if (SCLR) begin
            r_q <= '0;
        end else if (CE) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign Q = r_q;

endmodule

// File: rtl/cnt_sched.sv
// Arbitrated interval scheduler: grants one requester a counted interval of latched length.
// Define CNT_SCHED_RR_EN for round-robin arbitration; otherwise lowest index wins.
module cnt_sched
    import cnt_sched_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic                   C,
    input  logic                   CLR,
    input  logic [N_REQ-1:0]       REQ,
    input  logic [N_REQ*CNT_W-1:0] LEN,
    input  logic                   PAUSE,
    output logic [N_REQ-1:0]       GNT,
    output logic [N_REQ-1:0]       DONE,
    output logic                   BUSY,
    output logic [CNT_W-1:0]       Q
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    state_t           r_state;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] r_done;
    logic [CNT_W-1:0] r_len;

    logic [IDX_W-1:0] w_win;
    logic [IDX_W-1:0] w_cand;
    logic [CNT_W-1:0] w_q;
    logic             w_any;
    logic             w_own;
    logic             w_at_end;
    logic             w_sclr;
    logic             w_ce;

`ifdef CNT_SCHED_RR_EN
    logic [IDX_W-1:0] r_ptr;
    logic             w_found;

    // Search starts one past the last winner and wraps around.
    always_comb begin
        w_win   = '0;
        w_cand  = '0;
        w_found = 1'b0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            w_cand = IDX_W'((32'(r_ptr) + k) % N_REQ);
            if (!w_found && REQ[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end
`else
    // Scan downward so the lowest requesting index is the last one written.
    always_comb begin
        w_win  = '0;
        w_cand = '0;
        for (int unsigned k = N_REQ; k > 0; k--) begin
            w_cand = IDX_W'(k - 1);
            if (REQ[w_cand]) begin
                w_win = w_cand;
            end
        end
    end
`endif

    assign w_any    = |REQ;
    assign w_own    = |(REQ & r_gnt);
    assign w_at_end = (w_q == r_len);
    assign w_sclr   = (r_state == ST_IDLE) && w_any;
    // Terminal compare gates the increment, so the counter never wraps.
    assign w_ce     = (r_state == ST_COUNT) && w_own && !PAUSE && !w_at_end;

    cnt_sched_ctr #(
        .CNT_W (CNT_W)
    ) u_ctr (
        .C    (C),
        .CLR  (CLR),
        .SCLR (w_sclr),
        .CE   (w_ce),
        .Q    (w_q)
    );

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_done  <= '0;
            r_len   <= '0;
`ifdef CNT_SCHED_RR_EN
            r_ptr   <= IDX_W'(N_REQ - 1);
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= '0;
                    if (w_any) begin
                        r_len   <= LEN[w_win*CNT_W +: CNT_W];
                        r_gnt   <= N_REQ'(1) << w_win;
                        r_state <= ST_COUNT;
`ifdef CNT_SCHED_RR_EN
                        r_ptr   <= w_win;
`endif
                    end
                end
                ST_COUNT: begin
                    // A dropped request aborts even while paused.
                    if (!w_own) begin
                        r_gnt   <= '0;
                        r_state <= ST_IDLE;
                    end else if (!PAUSE && w_at_end) begin
                        r_done  <= r_gnt;
                        r_gnt   <= '0;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_gnt   <= '0;
                    r_done  <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign GNT  = r_gnt;
    assign DONE = r_done;
    assign BUSY = (r_state != ST_IDLE);
    assign Q    = w_q;

endmodule

// File: tb/tb_cnt_sched.sv
// Bench for cnt_sched: directed scenarios plus randomized traffic against a transaction-level model.
module tb_cnt_sched;

    localparam int N = 4;
    localparam int W = 4;

    logic           C = 1'b0;
    logic           CLR = 1'b1;
    logic [N-1:0]   REQ = '0;
    logic [N*W-1:0] LEN = '0;
    logic           PAUSE = 1'b0;
    logic [N-1:0]   GNT;
    logic [N-1:0]   DONE;
    logic           BUSY;
    logic [W-1:0]   Q;

    cnt_sched #(
        .N_REQ (N),
        .CNT_W (W)
    ) dut (
        .C     (C),
        .CLR   (CLR),
        .REQ   (REQ),
        .LEN   (LEN),
        .PAUSE (PAUSE),
        .GNT   (GNT),
        .DONE  (DONE),
        .BUSY  (BUSY),
        .Q     (Q)
    );

    always #5 C = ~C;

    int n_vec = 0;
    int n_err = 0;

    // Reference: phase 0 idle, 1 interval running, 2 completion cycle.
    int m_ph, m_q, m_len, m_w, m_dw, m_ptr;

    int gnt_cnt, done_cnt;
    int order[$];
    int qlog[$];
    logic [N-1:0] prev_gnt;
    bit auto_drop = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r);
`ifdef CNT_SCHED_RR_EN
        for (int k = 1; k <= N; k++) begin
            if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
`else
        for (int i = 0; i < N; i++) begin
            if (r[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_ph = 0; m_q = 0; m_len = 0; m_w = -1; m_dw = -1; m_ptr = N - 1;
    endtask

    task automatic model_edge();
        case (m_ph)
            0: begin
                m_dw = -1;
                if (REQ != 0) begin
                    m_w   = pick(REQ);
                    m_len = int'((LEN >> (m_w * W)) % (1 << W));
                    m_q   = 0;
                    m_ph  = 1;
                    m_ptr = m_w;
                end
            end
            1: begin
                if (!REQ[m_w]) begin
                    m_w = -1; m_ph = 0;
                end else if (!PAUSE) begin
                    if (m_q == m_len) begin
                        m_dw = m_w; m_w = -1; m_ph = 2;
                    end else begin
                        m_q++;
                    end
                end
            end
            default: begin
                m_dw = -1; m_ph = 0;
            end
        endcase
    endtask

    task automatic check_all();
        chk("GNT",  32'(GNT),  (m_w  >= 0) ? (32'd1 << m_w)  : 32'd0);
        chk("DONE", 32'(DONE), (m_dw >= 0) ? (32'd1 << m_dw) : 32'd0);
        chk("BUSY", 32'(BUSY), (m_ph != 0) ? 32'd1 : 32'd0);
        chk("Q",    32'(Q),    32'(m_q));
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle();
        @(posedge C);
        model_edge();
        #1;
        check_all();
        if (GNT != 0) begin
            gnt_cnt++;
            qlog.push_back(int'(Q));
        end
        if (DONE != 0) done_cnt++;
        if (GNT != 0 && prev_gnt == 0) begin
            for (int i = 0; i < N; i++) if (GNT[i]) order.push_back(i);
        end
        prev_gnt = GNT;
        if (auto_drop) REQ = REQ & ~DONE;
        @(negedge C);
    endtask

    task automatic do_clr();
        CLR = 1'b1;
        #1;
        model_reset();
        chk("CLR_GNT",  32'(GNT),  32'd0);
        chk("CLR_DONE", 32'(DONE), 32'd0);
        chk("CLR_BUSY", 32'(BUSY), 32'd0);
        chk("CLR_Q",    32'(Q),    32'd0);
        @(posedge C);
        #1;
        chk("CLR_HOLD_GNT", 32'(GNT), 32'd0);
        @(negedge C);
        CLR = 1'b0;
        prev_gnt = '0;
    endtask

    task automatic set_len(input int i, input int v);
        LEN[i*W +: W] = W'(v);
    endtask

`ifdef CNT_SCHED_RR_EN
    int exp_ord[5] = '{0, 1, 2, 3, 0};
`else
    int exp_ord[3] = '{0, 0, 0};
`endif

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        model_reset();
        prev_gnt = '0;
        @(negedge C);
        do_clr();

        // Basic 4-cycle interval on requester 0.
        REQ = 4'b0001; set_len(0, 3);
        gnt_cnt = 0; done_cnt = 0; qlog.delete();
        for (int i = 0; i < 7; i++) cycle();
        chk("R029_gnt_cycles", 32'(gnt_cnt), 32'd4);
        chk("R029_done_pulses", 32'(done_cnt), 32'd1);
        chk("R029_qlog_len", 32'(qlog.size()), 32'd4);
        for (int i = 0; i < 4 && i < qlog.size(); i++) chk("R029_q_seq", 32'(qlog[i]), 32'(i));

        // Pause for two cycles at Q=2 stretches the grant by two.
        REQ = 4'b0001; set_len(0, 5);
        gnt_cnt = 0; done_cnt = 0; hit = 0;
        for (int i = 0; i < 16; i++) begin
            if (!hit && Q == 2 && GNT == 4'b0001) begin
                hit = 1;
                PAUSE = 1'b1;
                cycle();
                chk("R030_q_held1", 32'(Q), 32'd2);
                cycle();
                chk("R030_q_held2", 32'(Q), 32'd2);
                PAUSE = 1'b0;
            end else begin
                cycle();
            end
        end
        chk("R030_pause_hit", 32'(hit), 32'd1);
        chk("R030_gnt_cycles", 32'(gnt_cnt), 32'd8);
        chk("R030_done_pulses", 32'(done_cnt), 32'd1);

        // All requesters held with zero length: arbitration order.
        do_clr();
        auto_drop = 1'b0;
        REQ = 4'b1111; LEN = '0; order.delete();
        for (int i = 0; i < 15; i++) cycle();
        REQ = '0;
        for (int i = 0; i < 3; i++) cycle();
        auto_drop = 1'b1;
        chk("R031_grants", 32'(order.size() >= $size(exp_ord)), 32'd1);
        for (int i = 0; i < $size(exp_ord) && i < order.size(); i++)
            chk("R031_order", 32'(order[i]), 32'(exp_ord[i]));

        // Abort by dropping the request mid-interval.
        REQ = 4'b0100; set_len(2, 6); done_cnt = 0; hit = 0;
        for (int i = 0; i < 10 && !hit; i++) begin
            cycle();
            if (Q == 1 && GNT == 4'b0100) hit = 1;
        end
        chk("R032_reached_q1", 32'(hit), 32'd1);
        REQ = '0;
        cycle();
        chk("R032_gnt", 32'(GNT), 32'd0);
        chk("R032_busy", 32'(BUSY), 32'd0);
        chk("R032_q", 32'(Q), 32'd1);
        cycle();
        chk("R032_no_done", 32'(done_cnt), 32'd0);

        // Asynchronous clear mid-interval.
        REQ = 4'b0001; set_len(0, 9); done_cnt = 0; hit = 0;
        for (int i = 0; i < 12 && !hit; i++) begin
            cycle();
            if (Q == 4 && GNT == 4'b0001) hit = 1;
        end
        chk("R033_reached_q4", 32'(hit), 32'd1);
        #2;
        do_clr();
        REQ = '0;
        for (int i = 0; i < 4; i++) cycle();
        chk("R033_no_done", 32'(done_cnt), 32'd0);

        // Maximum length saturates at all-ones.
        REQ = 4'b0010; set_len(1, 15); gnt_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 20; i++) cycle();
        chk("R034_gnt_cycles", 32'(gnt_cnt), 32'd16);
        chk("R034_done_pulses", 32'(done_cnt), 32'd1);
        chk("R034_q_final", 32'(Q), 32'd15);

        // Randomized traffic with pauses, aborts, length churn and clears.
        for (int n = 0; n < 500; n++) begin
            LEN = N*W'($urandom);
            PAUSE = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++) begin
                if (!REQ[i]) begin
                    if ($urandom_range(0, 2) == 0) REQ[i] = 1'b1;
                end else if (GNT[i] && $urandom_range(0, 29) == 0) begin
                    REQ[i] = 1'b0;
                end
            end
            if ($urandom_range(0, 149) == 0) do_clr();
            else cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cnt_sched.md
CNT_SCHED -- requirements
Module: cnt_sched

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter CNT_W, default 4, width of shared up-counter and of each length field.
REQ-003 SHALL have port C  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port CLR  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port REQ  input  N_REQ  per-requester interval request, level, held until DONE.
REQ-006 SHALL have port LEN  input  N_REQ*CNT_W  per-requester terminal count; field i = bits [i*CNT_W +: CNT_W].
REQ-007 SHALL have port PAUSE  input  1  active-high hold; counter clock-enable = !PAUSE.
REQ-008 SHALL have port GNT  output  N_REQ  one-hot grant, registered.
REQ-009 SHALL have port DONE  output  N_REQ  one-cycle completion pulse to granted requester, registered.
REQ-010 SHALL have port BUSY  output  1  high in COUNT and DONE states.
REQ-011 SHALL have port Q  output  CNT_W  shared counter value.

Function
REQ-012 SHALL implement states IDLE, COUNT, DONE.
REQ-013 IDLE: at edge with any REQ high SHALL pick winner w, latch LEN[w], clear Q to 0, set GNT[w], enter COUNT; no REQ -> stay IDLE, Q holds.
REQ-014 COUNT, PAUSE=0: Q != latched length -> Q <= Q+1; Q == latched length -> enter DONE, GNT <= 0, DONE[w] <= 1, Q holds.
REQ-015 COUNT, PAUSE=1: Q, state, GNT hold; PAUSE SHALL be ignored in IDLE and DONE.
REQ-016 DONE: DONE <= 0, enter IDLE next edge; DONE high exactly one cycle.
REQ-017 Unpaused grant SHALL last exactly latched-length+1 cycles; LEN=0 gives one-cycle grant with Q=0.
REQ-018 LEN change during COUNT SHALL have no effect; only the value latched at grant is used.
REQ-019 REQ[w] low during COUNT SHALL abort: GNT <= 0, no DONE pulse, enter IDLE, Q holds.
REQ-020 Counter SHALL never wrap: terminal compare precedes increment; max length 2^CNT_W-1 reaches all-ones then stops.
REQ-021 Minimum spacing between grants SHALL be one IDLE cycle after DONE; GNT never high in two consecutive states without an intervening IDLE.
REQ-022 At most one GNT bit and one DONE bit SHALL be high at any time.

Reset
REQ-023 CLR high SHALL force immediately: state IDLE, GNT 0, DONE 0, BUSY 0, Q 0, latched length 0, priority pointer N_REQ-1.
REQ-024 CLR mid-COUNT SHALL abort with no DONE pulse; arbitration resumes at first edge after CLR deasserts.

Configuration
REQ-025 Macro CNT_SCHED_RR_EN defined: round-robin; search starts at index after last winner, pointer updated on each grant.
REQ-026 Macro CNT_SCHED_RR_EN undefined: fixed priority, lowest index wins; pointer logic absent.

Structure
REQ-027 Shared package cnt_sched_pkg SHALL hold the state enum (IDLE/COUNT/DONE) and default parameter constants.
REQ-028 Counter SHALL be sub-module cnt_sched_ctr (CNT_W up-counter, async CLR, sync clear, CE); arbitration and FSM in cnt_sched.

Verification
REQ-029 CLR pulse, then REQ=0001, LEN[0]=3 -> GNT=0001 four cycles, Q 0,1,2,3, DONE=0001 one cycle, BUSY low after.
REQ-030 REQ=0001 LEN[0]=5, PAUSE high 2 cycles at Q=2 -> Q holds 2 for 2 cycles, grant 8 cycles total, single DONE.
REQ-031 REQ=1111 held, LEN all 0, RR on -> grant order 0,1,2,3,0; RR off -> 0,0,0.
REQ-032 REQ[2] dropped at Q=1 of LEN=6 -> GNT clears next edge, no DONE, IDLE.
REQ-033 CLR asserted at Q=4 of LEN=9 -> Q,GNT,DONE,BUSY 0 immediately; no DONE after release.
REQ-034 LEN[1]=15, CNT_W=4 -> Q reaches 15, DONE pulses, Q stays 15 (no wrap to 0).
